// File: rtl/mdio_master.sv
// -----------------------------------------------------------------------------
// mdio_master
//
// Clause-22 MDIO/SMI management master for the Ethernet PHY, clk_tcxo domain.
// Serialises read/write register frames onto mdc and the tristated MDIO pin
// (mdio_i / mdio_o / mdio_t) and arbitrates the bus between the host command
// port and an optional autonomous link-status poller.
//
// Frame: PREAMBLE_BITS x '1', ST=01, OP (01 write / 10 read), PHYAD[4:0],
// REGAD[4:0], TA (2 bits), DATA[15:0], all MSB first. Each bit is CLK_DIV
// cycles with mdc=0 followed by CLK_DIV cycles with mdc=1. The response
// strobe lands on the last clk of the last bit, so rsp_valid fires exactly
// (PREAMBLE_BITS+32)*2*CLK_DIV cycles after the accepting cycle.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   host command handshake
//   cmd_write             1 = write, 0 = read
//   cmd_phy_addr/reg_addr PHYAD / REGAD
//   cmd_wdata             write data
//   rsp_valid             1-cycle pulse at end of a host frame
//   rsp_rdata, rsp_err    read data (0 for writes), missing-PHY flag
//   busy                  frame in progress
//   mdc                   MDIO clock
//   mdio_i/mdio_o/mdio_t  pin input, pin output value, 1 = drive mdio_o
//   poll_status           last successfully polled register value
//   poll_update           1-cycle pulse when poll_status is refreshed
//
// Build option: define MDIO_POLL_EN to build the periodic poller that reads
// POLL_PHY_ADDR/POLL_REG_ADDR every POLL_INTERVAL cycles. Without it,
// poll_status and poll_update are tied to 0.
// -----------------------------------------------------------------------------
module mdio_master #(
  parameter int          CLK_DIV       = 16,
  parameter int          PREAMBLE_BITS = 32,
  parameter logic [4:0]  POLL_PHY_ADDR = 5'd0,
  parameter logic [4:0]  POLL_REG_ADDR = 5'd1,
  parameter logic [23:0] POLL_INTERVAL = 24'd1000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_t,
  output logic [15:0] poll_status,
  output logic        poll_update
);

  localparam int CW = $clog2(2 * CLK_DIV);
  localparam int BW = $clog2(PREAMBLE_BITS + 16) + 1;

  if (CLK_DIV < 2 || PREAMBLE_BITS < 1 || POLL_INTERVAL == 24'd0) begin : g_bad_params
    $error("mdio_master: illegal parameter value");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cyc_q, cyc_d;       // position inside the current bit
  logic [BW-1:0]   bit_q, bit_d;       // bits remaining in the current field, minus 1
  logic            mdc_q, mdc_d;
  logic            mdio_o_q, mdio_o_d;
  logic            mdio_t_q, mdio_t_d;
  logic [31:0]     tx_q, tx_d;         // ST/OP/PHYAD/REGAD/TA/DATA, MSB out first
  logic [15:0]     rx_q, rx_d;
  logic            is_write_q, is_write_d;
  logic            is_poll_q, is_poll_d;
  logic            ta_err_q, ta_err_d;
  logic [15:0]     rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;

  logic            start_host, start_poll, poll_pending;
  logic            frame_end;          // cycle that moves DATA -> DONE
  logic            sample, bit_end;
  logic            wr_sel;
  logic [4:0]      phy_sel, reg_sel;
  state_t          nxt;

  assign cmd_ready  = (state_q == S_IDLE) && !poll_pending;
  assign start_host = cmd_valid && cmd_ready;
  assign sample     = (cyc_q == CW'(CLK_DIV));
  assign bit_end    = (cyc_q == CW'(2 * CLK_DIV - 1));

  // A pending poll wins over the host; poll frames are always reads.
  assign wr_sel  = !start_poll && cmd_write;
  assign phy_sel = start_poll ? POLL_PHY_ADDR : cmd_phy_addr;
  assign reg_sel = start_poll ? POLL_REG_ADDR : cmd_reg_addr;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d     = state_q;
    cyc_d       = cyc_q;
    bit_d       = bit_q;
    mdc_d       = mdc_q;
    mdio_o_d    = mdio_o_q;
    mdio_t_d    = mdio_t_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    is_write_d  = is_write_q;
    is_poll_d   = is_poll_q;
    ta_err_d    = ta_err_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    frame_end   = 1'b0;
    nxt         = state_q;

    case (state_q)
      S_IDLE: begin
        mdc_d    = 1'b0;
        mdio_o_d = 1'b0;
        mdio_t_d = 1'b0;
        if (start_poll || start_host) begin
          state_d    = S_PRE;
          cyc_d      = '0;
          bit_d      = BW'(PREAMBLE_BITS - 1);
          mdio_o_d   = 1'b1;
          mdio_t_d   = 1'b1;
          is_write_d = wr_sel;
          is_poll_d  = start_poll;
          ta_err_d   = 1'b0;
          rx_d       = '0;
          tx_d       = {2'b01, (wr_sel ? 2'b01 : 2'b10), phy_sel, reg_sel,
                        (wr_sel ? 2'b10 : 2'b00), (wr_sel ? cmd_wdata : 16'h0000)};
        end
      end

      S_DONE: begin
        state_d  = S_IDLE;
        mdc_d    = 1'b0;
        mdio_o_d = 1'b0;
        mdio_t_d = 1'b0;
      end

      default: begin  // S_PRE, S_HDR, S_TA, S_DATA
        cyc_d = cyc_q + CW'(1);
        mdc_d = (cyc_q >= CW'(CLK_DIV - 1));

        if (sample && !is_write_q) begin
          if (state_q == S_TA && bit_q == '0) ta_err_d = mdio_i;
          if (state_q == S_DATA)              rx_d     = {rx_q[14:0], mdio_i};
        end

        if (state_q == S_DATA && bit_q == '0 && cyc_q == CW'(2 * CLK_DIV - 2)) begin
          // DONE is the final high-phase clk of the last data bit.
          frame_end = 1'b1;
          state_d   = S_DONE;
          if (!is_poll_q) begin
            rsp_rdata_d = is_write_q ? 16'h0000 : rx_d;
            rsp_err_d   = !is_write_q && ta_err_d;
          end
        end else if (bit_end) begin
          cyc_d = '0;
          mdc_d = 1'b0;
          case (state_q)
            S_PRE:   if (bit_q == '0) begin nxt = S_HDR;  bit_d = BW'(13); end
                     else bit_d = bit_q - BW'(1);
            S_HDR:   if (bit_q == '0) begin nxt = S_TA;   bit_d = BW'(1);  end
                     else bit_d = bit_q - BW'(1);
            S_TA:    if (bit_q == '0) begin nxt = S_DATA; bit_d = BW'(15); end
                     else bit_d = bit_q - BW'(1);
            default: bit_d = bit_q - BW'(1);
          endcase
          state_d = nxt;
          if (nxt == S_PRE) begin
            mdio_o_d = 1'b1;
            mdio_t_d = 1'b1;
          end else begin
            mdio_o_d = tx_q[31];
            tx_d     = {tx_q[30:0], 1'b0};
            // Reads release the pin from the first turnaround bit onward.
            mdio_t_d = is_write_q || (nxt == S_HDR);
          end
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cyc_q       <= '0;
      bit_q       <= '0;
      mdc_q       <= 1'b0;
      mdio_o_q    <= 1'b0;
      mdio_t_q    <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      is_write_q  <= 1'b0;
      is_poll_q   <= 1'b0;
      ta_err_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      bit_q       <= bit_d;
      mdc_q       <= mdc_d;
      mdio_o_q    <= mdio_o_d;
      mdio_t_q    <= mdio_t_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      is_write_q  <= is_write_d;
      is_poll_q   <= is_poll_d;
      ta_err_q    <= ta_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign mdc       = mdc_q;
  assign mdio_o    = mdio_o_q;
  assign mdio_t    = mdio_t_q;
  assign rsp_valid = (state_q == S_DONE) && !is_poll_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

`ifdef MDIO_POLL_EN
  logic [23:0] poll_cnt_q, poll_cnt_d;
  logic        poll_pending_q, poll_pending_d;
  logic [15:0] poll_status_q, poll_status_d;
  logic        poll_expire;

  assign start_poll   = (state_q == S_IDLE) && poll_pending_q;
  assign poll_pending = poll_pending_q;
  assign poll_expire  = (poll_cnt_q == POLL_INTERVAL - 24'd1);

  always_comb begin
    poll_cnt_d     = poll_expire ? 24'd0 : poll_cnt_q + 24'd1;
    // An expiry while a request is still pending merges into it; an expiry
    // on the start cycle re-arms for the next frame.
    poll_pending_d = poll_expire || (poll_pending_q && !start_poll);
    poll_status_d  = poll_status_q;
    if (frame_end && is_poll_q && !ta_err_d) poll_status_d = rx_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      poll_cnt_q     <= '0;
      poll_pending_q <= 1'b0;
      poll_status_q  <= '0;
    end else begin
      poll_cnt_q     <= poll_cnt_d;
      poll_pending_q <= poll_pending_d;
      poll_status_q  <= poll_status_d;
    end
  end

  assign poll_status = poll_status_q;
  assign poll_update = (state_q == S_DONE) && is_poll_q && !ta_err_q;
`else
  assign start_poll   = 1'b0;
  assign poll_pending = 1'b0;
  assign poll_status  = 16'h0000;
  assign poll_update  = 1'b0;
`endif

endmodule
